// File: rtl/reorder_buffer_mp.sv
// Parametrised in-order reorder buffer: one dispatch per cycle, N_CDB write-back channels, in-order commit and mispredict rollback.
// Define ROB_PERF_EN to add saturating commit/rollback counters on perf_commit_o/perf_rollback_o.
module reorder_buffer_mp #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ID_W        = $clog2(DEPTH) + 1,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned N_CDB       = 2,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_en_i,
  input  logic [REG_W-1:0]        alloc_rd_i,
  output logic [ID_W-1:0]         alloc_id_o,
  output logic                    full_o,
  output logic                    empty_o,
  input  logic [ID_W-1:0]         q1_i,
  input  logic [ID_W-1:0]         q2_i,
  output logic                    q1_ready_o,
  output logic                    q2_ready_o,
  output logic [DATA_W-1:0]       q1_data_o,
  output logic [DATA_W-1:0]       q2_data_o,
  input  logic [N_CDB-1:0]        cdb_valid_i,
  input  logic [N_CDB*ID_W-1:0]   cdb_id_i,
  input  logic [N_CDB*DATA_W-1:0] cdb_data_i,
  input  logic [N_CDB-1:0]        cdb_jump_i,
  input  logic [N_CDB*ADDR_W-1:0] cdb_tpc_i,
  input  logic [ID_W-1:0]         store_id_i,
  output logic                    commit_o,
  output logic [REG_W-1:0]        commit_rd_o,
  output logic [ID_W-1:0]         commit_id_o,
  output logic [DATA_W-1:0]       commit_data_o,
  output logic                    rollback_o,
`ifdef ROB_PERF_EN
  output logic [31:0]             perf_commit_o,
  output logic [31:0]             perf_rollback_o,
`endif
  output logic [ADDR_W-1:0]       rollback_pc_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [ID_W-1:0] DEPTH_C  = ID_W'(DEPTH);
  localparam logic [ID_W-1:0] MARGIN_C = ID_W'(FULL_MARGIN);

  logic              busy_q  [DEPTH];
  logic              busy_d  [DEPTH];
  logic              ready_q [DEPTH];
  logic              ready_d [DEPTH];
  logic              jump_q  [DEPTH];
  logic              jump_d  [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [REG_W-1:0]  rd_d    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [ADDR_W-1:0] tpc_q   [DEPTH];
  logic [ADDR_W-1:0] tpc_d   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, widx, sidx;
  logic [ID_W-1:0]   count_q, count_d, wid;
  logic              commit_q, commit_d, rollback_q, rollback_d;
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [ID_W-1:0]   commit_id_q, commit_id_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic [ADDR_W-1:0] rollback_pc_q, rollback_pc_d;
  logic              do_commit, do_alloc;

  assign alloc_id_o    = ID_W'(tail_q) + ID_W'(1);
  assign empty_o       = (count_q == '0);
  assign full_o        = ((DEPTH_C - count_q) <= MARGIN_C);
  assign commit_o      = commit_q;
  assign commit_rd_o   = commit_rd_q;
  assign commit_id_o   = commit_id_q;
  assign commit_data_o = commit_data_q;
  assign rollback_o    = rollback_q;
  assign rollback_pc_o = rollback_pc_q;

  // Stored result, overridden by a matching CDB channel this cycle (later channel wins).
  function automatic logic [DATA_W:0] lookup(input logic [ID_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    if (tag != '0) begin
      r = {ready_q[PTR_W'(tag - ID_W'(1))], data_q[PTR_W'(tag - ID_W'(1))]};
      for (int unsigned k = 0; k < N_CDB; k++)
        if (cdb_valid_i[k] && cdb_id_i[k*ID_W +: ID_W] == tag)
          r = {1'b1, cdb_data_i[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    {q1_ready_o, q1_data_o} = lookup(q1_i);
    {q2_ready_o, q2_data_o} = lookup(q2_i);
  end

  always_comb begin
    busy_d = busy_q;  ready_d = ready_q;  jump_d = jump_q;
    rd_d   = rd_q;    data_d  = data_q;   tpc_d  = tpc_q;
    head_d = head_q;  tail_d  = tail_q;   count_d = count_q;
    commit_d      = 1'b0;
    rollback_d    = 1'b0;
    commit_rd_d   = commit_rd_q;
    commit_id_d   = commit_id_q;
    commit_data_d = commit_data_q;
    rollback_pc_d = rollback_pc_q;
    do_commit     = 1'b0;
    do_alloc      = 1'b0;
    widx          = '0;
    wid           = '0;
    sidx          = PTR_W'(store_id_i - ID_W'(1));
    if (rollback_q) begin
      busy_d  = '{default: '0};
      ready_d = '{default: '0};
      jump_d  = '{default: '0};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      do_commit = busy_q[head_q] && ready_q[head_q];
      do_alloc  = alloc_en_i && (count_q != DEPTH_C);
      for (int unsigned k = 0; k < N_CDB; k++) begin
        wid  = cdb_id_i[k*ID_W +: ID_W];
        widx = PTR_W'(wid - ID_W'(1));
        if (cdb_valid_i[k] && wid != '0 && busy_q[widx]) begin
          ready_d[widx] = 1'b1;
          data_d[widx]  = cdb_data_i[k*DATA_W +: DATA_W];
          jump_d[widx]  = cdb_jump_i[k];
          tpc_d[widx]   = cdb_tpc_i[k*ADDR_W +: ADDR_W];
        end
      end
      if (store_id_i != '0 && busy_q[sidx])
        ready_d[sidx] = 1'b1;
      if (do_commit) begin
        commit_d       = 1'b1;
        commit_rd_d    = rd_q[head_q];
        commit_id_d    = ID_W'(head_q) + ID_W'(1);
        commit_data_d  = data_q[head_q];
        busy_d[head_q] = 1'b0;
        head_d         = head_q + PTR_W'(1);
        if (jump_q[head_q]) begin
          rollback_d    = 1'b1;
          rollback_pc_d = tpc_q[head_q];
        end
      end
      if (do_alloc) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = alloc_rd_i;
        data_d[tail_q]  = '0;
        jump_d[tail_q]  = 1'b0;
        tpc_d[tail_q]   = '0;
        tail_d          = tail_q + PTR_W'(1);
      end
      if (do_alloc && !do_commit)      count_d = count_q + ID_W'(1);
      else if (!do_alloc && do_commit) count_d = count_q - ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '{default: '0};
      ready_q <= '{default: '0};
      jump_q  <= '{default: '0};
      rd_q    <= '{default: '0};
      data_q  <= '{default: '0};
      tpc_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      commit_q      <= 1'b0;
      rollback_q    <= 1'b0;
      commit_rd_q   <= '0;
      commit_id_q   <= '0;
      commit_data_q <= '0;
      rollback_pc_q <= '0;
    end else if (rdy) begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      jump_q  <= jump_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      tpc_q   <= tpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      commit_q      <= commit_d;
      rollback_q    <= rollback_d;
      commit_rd_q   <= commit_rd_d;
      commit_id_q   <= commit_id_d;
      commit_data_q <= commit_data_d;
      rollback_pc_q <= rollback_pc_d;
    end
  end

`ifdef ROB_PERF_EN
  logic [31:0] perf_commit_q, perf_rollback_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_commit_q   <= '0;
      perf_rollback_q <= '0;
    end else if (rdy) begin
      if (commit_d && perf_commit_q != '1)     perf_commit_q   <= perf_commit_q + 32'd1;
      if (rollback_d && perf_rollback_q != '1) perf_rollback_q <= perf_rollback_q + 32'd1;
    end
  end

  assign perf_commit_o   = perf_commit_q;
  assign perf_rollback_o = perf_rollback_q;
`endif

endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed self-checking bench for reorder_buffer_mp at default parameters (DEPTH=16, N_CDB=2, FULL_MARGIN=2).
module tb_reorder_buffer_mp;
  localparam int ID_W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        alloc_en_i = 1'b0;
  logic [4:0]  alloc_rd_i = '0;
  logic [4:0]  alloc_id_o;
  logic        full_o, empty_o;
  logic [4:0]  q1_i = '0, q2_i = '0;
  logic        q1_ready_o, q2_ready_o;
  logic [31:0] q1_data_o, q2_data_o;
  logic [1:0]  cdb_valid_i = '0;
  logic [9:0]  cdb_id_i = '0;
  logic [63:0] cdb_data_i = '0;
  logic [1:0]  cdb_jump_i = '0;
  logic [63:0] cdb_tpc_i = '0;
  logic [4:0]  store_id_i = '0;
  logic        commit_o;
  logic [4:0]  commit_rd_o;
  logic [4:0]  commit_id_o;
  logic [31:0] commit_data_o;
  logic        rollback_o;
  logic [31:0] rollback_pc_o;

  int errors = 0;
  int checks = 0;

  reorder_buffer_mp dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_en_i(alloc_en_i), .alloc_rd_i(alloc_rd_i), .alloc_id_o(alloc_id_o),
    .full_o(full_o), .empty_o(empty_o),
    .q1_i(q1_i), .q2_i(q2_i),
    .q1_ready_o(q1_ready_o), .q2_ready_o(q2_ready_o),
    .q1_data_o(q1_data_o), .q2_data_o(q2_data_o),
    .cdb_valid_i(cdb_valid_i), .cdb_id_i(cdb_id_i), .cdb_data_i(cdb_data_i),
    .cdb_jump_i(cdb_jump_i), .cdb_tpc_i(cdb_tpc_i), .store_id_i(store_id_i),
    .commit_o(commit_o), .commit_rd_o(commit_rd_o), .commit_id_o(commit_id_o),
    .commit_data_o(commit_data_o), .rollback_o(rollback_o), .rollback_pc_o(rollback_pc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_en_i = 1'b0; cdb_valid_i = '0; cdb_jump_i = '0; store_id_i = '0;
    q1_i = '0; q2_i = '0; rdy = 1'b1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic set_cdb(input int k, input logic [4:0] id, input logic [31:0] data,
                         input logic jump, input logic [31:0] tpc);
    cdb_valid_i[k]          = 1'b1;
    cdb_id_i[k*ID_W +: ID_W] = id;
    cdb_data_i[k*32 +: 32]  = data;
    cdb_jump_i[k]           = jump;
    cdb_tpc_i[k*32 +: 32]   = tpc;
  endtask

  task automatic clr_cdb();
    cdb_valid_i = '0;
    cdb_jump_i  = '0;
  endtask

  task automatic alloc_n(input int n);
    alloc_en_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      alloc_rd_i = 5'(i + 5);
      tick();
    end
    alloc_en_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty_o !== 1'b1 || commit_o !== 1'b0 || rollback_o !== 1'b0 || alloc_id_o !== 5'd1) begin
      errors++; $display("FAIL reset_state: empty=%b commit=%b rollback=%b id=%0d, need 1 0 0 1", empty_o, commit_o, rollback_o, alloc_id_o); end
    alloc_n(3);
    checks++; if (alloc_id_o !== 5'd4 || empty_o !== 1'b0) begin
      errors++; $display("FAIL reset_pre: id=%0d empty=%b, need 4 0", alloc_id_o, empty_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (empty_o !== 1'b1 || commit_o !== 1'b0 || alloc_id_o !== 5'd1 || full_o !== 1'b0) begin
      errors++; $display("FAIL reset_async: empty=%b commit=%b id=%0d full=%b, need 1 0 1 0", empty_o, commit_o, alloc_id_o, full_o); end
    rst = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    alloc_n(13);
    checks++; if (full_o !== 1'b0 || alloc_id_o !== 5'd14) begin
      errors++; $display("FAIL fill_13: full=%b id=%0d, need 0 14", full_o, alloc_id_o); end
    alloc_n(1);
    checks++; if (full_o !== 1'b1 || alloc_id_o !== 5'd15) begin
      errors++; $display("FAIL fill_14: full=%b id=%0d, need 1 15", full_o, alloc_id_o); end
    alloc_n(2);
    checks++; if (full_o !== 1'b1 || alloc_id_o !== 5'd1 || empty_o !== 1'b0) begin
      errors++; $display("FAIL fill_16: full=%b id=%0d empty=%b, need 1 1 0", full_o, alloc_id_o, empty_o); end
    alloc_n(1);
    checks++; if (alloc_id_o !== 5'd1 || commit_o !== 1'b0) begin
      errors++; $display("FAIL fill_17_ignored: id=%0d commit=%b, need 1 0", alloc_id_o, commit_o); end
  endtask

  task automatic test_inorder();
    do_reset();
    alloc_n(2);
    set_cdb(1, 5'd2, 32'hBEEF, 1'b0, 32'h0);
    tick();
    clr_cdb();
    checks++; if (commit_o !== 1'b0) begin
      errors++; $display("FAIL inorder_hold: commit=%b, need 0", commit_o); end
    set_cdb(0, 5'd1, 32'h1234, 1'b0, 32'h0);
    q1_i = 5'd2;
    #1;
    checks++; if (q1_ready_o !== 1'b1 || q1_data_o !== 32'hBEEF) begin
      errors++; $display("FAIL inorder_query: ready=%b data=%h, need 1 0000beef", q1_ready_o, q1_data_o); end
    tick();
    clr_cdb();
    checks++; if (commit_o !== 1'b0) begin
      errors++; $display("FAIL inorder_latency: commit=%b, need 0", commit_o); end
    tick();
    checks++; if (commit_o !== 1'b1 || commit_id_o !== 5'd1 || commit_data_o !== 32'h1234 || commit_rd_o !== 5'd5) begin
      errors++; $display("FAIL inorder_c1: commit=%b id=%0d data=%h rd=%0d, need 1 1 00001234 5", commit_o, commit_id_o, commit_data_o, commit_rd_o); end
    tick();
    checks++; if (commit_o !== 1'b1 || commit_id_o !== 5'd2 || commit_data_o !== 32'hBEEF || commit_rd_o !== 5'd6) begin
      errors++; $display("FAIL inorder_c2: commit=%b id=%0d data=%h rd=%0d, need 1 2 0000beef 6", commit_o, commit_id_o, commit_data_o, commit_rd_o); end
    tick();
    checks++; if (commit_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL inorder_done: commit=%b empty=%b, need 0 1", commit_o, empty_o); end
    q1_i = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_n(5);
    set_cdb(0, 5'd1, 32'h11, 1'b0, 32'h0);
    tick();
    clr_cdb();
    alloc_en_i = 1'b1;
    tick();
    checks++; if (commit_o !== 1'b1 || commit_id_o !== 5'd1 || alloc_id_o !== 5'd7) begin
      errors++; $display("FAIL simul_commit: commit=%b id=%0d alloc_id=%0d, need 1 1 7", commit_o, commit_id_o, alloc_id_o); end
    // count is now 5: eight more allocations leave 3 free, the ninth leaves 2
    alloc_n(8);
    checks++; if (full_o !== 1'b0 || commit_o !== 1'b0) begin
      errors++; $display("FAIL simul_count13: full=%b commit=%b, need 0 0", full_o, commit_o); end
    alloc_n(1);
    checks++; if (full_o !== 1'b1) begin
      errors++; $display("FAIL simul_count14: full=%b, need 1", full_o); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(3);
    q1_i = 5'd3; q2_i = 5'd0;
    #1;
    checks++; if (q1_ready_o !== 1'b0) begin
      errors++; $display("FAIL bypass_idle: ready=%b, need 0", q1_ready_o); end
    set_cdb(1, 5'd3, 32'hCAFE, 1'b0, 32'h0);
    #1;
    checks++; if (q1_ready_o !== 1'b1 || q1_data_o !== 32'hCAFE) begin
      errors++; $display("FAIL bypass_hit: ready=%b data=%h, need 1 0000cafe", q1_ready_o, q1_data_o); end
    checks++; if (q2_ready_o !== 1'b0 || q2_data_o !== 32'h0) begin
      errors++; $display("FAIL bypass_tag0: ready=%b data=%h, need 0 00000000", q2_ready_o, q2_data_o); end
    set_cdb(0, 5'd3, 32'h1111, 1'b0, 32'h0);
    q2_i = 5'd3;
    #1;
    checks++; if (q2_ready_o !== 1'b1 || q2_data_o !== 32'hCAFE) begin
      errors++; $display("FAIL bypass_prio: ready=%b data=%h, need 1 0000cafe", q2_ready_o, q2_data_o); end
    tick();
    clr_cdb();
    q2_i = 5'd2;
    #1;
    checks++; if (q1_ready_o !== 1'b1 || q1_data_o !== 32'hCAFE || q2_ready_o !== 1'b0) begin
      errors++; $display("FAIL bypass_stored: r1=%b d1=%h r2=%b, need 1 0000cafe 0", q1_ready_o, q1_data_o, q2_ready_o); end
    q1_i = '0; q2_i = '0;
  endtask

  task automatic test_rollback();
    do_reset();
    alloc_n(4);
    set_cdb(0, 5'd1, 32'h55, 1'b1, 32'h80);
    tick();
    clr_cdb();
    tick();
    checks++; if (commit_o !== 1'b1 || rollback_o !== 1'b1 || rollback_pc_o !== 32'h80 || commit_id_o !== 5'd1) begin
      errors++; $display("FAIL rb_pulse: commit=%b rb=%b pc=%h id=%0d, need 1 1 00000080 1", commit_o, rollback_o, rollback_pc_o, commit_id_o); end
    alloc_en_i = 1'b1;
    set_cdb(1, 5'd2, 32'h77, 1'b0, 32'h0);
    tick();
    alloc_en_i = 1'b0;
    clr_cdb();
    checks++; if (rollback_o !== 1'b0 || commit_o !== 1'b0 || empty_o !== 1'b1 || alloc_id_o !== 5'd1) begin
      errors++; $display("FAIL rb_flush: rb=%b commit=%b empty=%b id=%0d, need 0 0 1 1", rollback_o, commit_o, empty_o, alloc_id_o); end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    rdy = 1'b0;
    alloc_en_i = 1'b1;
    tick();
    alloc_en_i = 1'b0;
    checks++; if (empty_o !== 1'b1 || alloc_id_o !== 5'd1) begin
      errors++; $display("FAIL rdy_hold: empty=%b id=%0d, need 1 1", empty_o, alloc_id_o); end
    rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_inorder();
    test_back_to_back();
    test_bypass();
    test_rollback();
    test_rdy_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
